// File: rtl/cpu_ctrl_seq_pkg.sv
// cpu_ctrl_seq_pkg: state encodings, instruction field layout, MM map and decode helper.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package cpu_ctrl_seq_pkg;

   // FSM state encodings (also the value visible through the MM STATE register)
   localparam logic [3:0] ST_READY      = 4'd0;
   localparam logic [3:0] ST_FETCH      = 4'd1;
   localparam logic [3:0] ST_WAIT_FETCH = 4'd2;
   localparam logic [3:0] ST_CALC       = 4'd3;
   localparam logic [3:0] ST_WAIT_CALC  = 4'd4;
   localparam logic [3:0] ST_LWST       = 4'd5;
   localparam logic [3:0] ST_WAIT_LWST  = 4'd6;
   localparam logic [3:0] ST_HALT       = 4'd7;
   localparam logic [3:0] ST_ERROR      = 4'd8;

   // Instruction field layout: type in the low bits, op directly above it
   localparam int TYPE_LSB = 0;
   localparam int TYPE_W   = 2;
   localparam int OP_LSB   = 2;
   localparam int OP_W     = 4;

   localparam logic [TYPE_W-1:0] TYPE_R  = 2'd0;
   localparam logic [TYPE_W-1:0] TYPE_I  = 2'd1;
   localparam logic [TYPE_W-1:0] TYPE_J  = 2'd2;
   localparam logic [TYPE_W-1:0] TYPE_LR = 2'd3;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_LW  = 4'd1;
   localparam logic [OP_W-1:0] OP_ST  = 4'd2;
   localparam logic [OP_W-1:0] OP_BE  = 4'd3;
   localparam logic [OP_W-1:0] OP_BNE = 4'd4;
   localparam logic [OP_W-1:0] OP_JR  = 4'd5;
   localparam logic [OP_W-1:0] OP_J   = 4'd6;
   localparam logic [OP_W-1:0] OP_JAL = 4'd7;

   // MM word addresses
   localparam int MM_STATE   = 0;
   localparam int MM_CTRL    = 1;
   localparam int MM_STATUS  = 2;
   localparam int MM_INSTCNT = 3;
   localparam int MM_CYCCNT  = 4;

   // CTRL / STATUS bit positions
   localparam int CTRL_BOOT = 0;
   localparam int CTRL_STEP = 1;
   localparam int CTRL_GO   = 2;
   localparam int STAT_ERR  = 0;
   localparam int STAT_HALT = 1;

   typedef struct packed {
      logic lwst;
      logic be;
      logic bne;
      logic jump;
      logic calc;
      logic is_j;
   } dec_t;

   // Classify the head instruction; eq is the branch operand comparison.
   function automatic dec_t decode(input logic valid,
                                   input logic [TYPE_W-1:0] ty,
                                   input logic [OP_W-1:0] op,
                                   input logic eq);
      dec_t d;
      logic is_i;
      is_i   = valid && (ty == TYPE_I);
      d.lwst = is_i && ((op == OP_LW) || (op == OP_ST));
      d.be   = is_i && (op == OP_BE) && eq;
      d.bne  = is_i && (op == OP_BNE) && !eq;
      d.is_j = valid && (ty == TYPE_J);
      d.jump = (valid && (((ty == TYPE_LR) && (op == OP_JR)) ||
                          ((ty == TYPE_J) && ((op == OP_J) || (op == OP_JAL)))))
               || d.be || d.bne;
      d.calc = valid && !d.lwst && !d.jump;
      return d;
   endfunction

endpackage

// File: rtl/cpu_ctrl_mmregs.sv
// cpu_ctrl_mmregs: CTRL/STATUS (and optional perf counter) registers plus MM read mux.
// Latency: read data and read-valid one cycle after i_read; write effects visible next cycle.
// Backpressure: none, every MM access completes in one cycle. Perf counters: CPU_CTRL_PERF_CNT_EN.
module cpu_ctrl_mmregs
   import cpu_ctrl_seq_pkg::*;
#(
   parameter int WORD_BITS = 32,
   parameter int ADDR_BITS = 3
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 read,
   input  logic                 write,
   input  logic [WORD_BITS-1:0] writedata,
   input  logic [3:0]           state,
   input  logic                 err_set,
   input  logic                 inst_complete,
   input  logic                 cyc_active,
   output logic                 ctrl_boot,
   output logic                 ctrl_step,
   output logic                 go_now,
   output logic                 state_wr,
   output logic                 err,
   output logic [WORD_BITS-1:0] readdata,
   output logic                 readdatavalid
);

   localparam logic [ADDR_BITS-1:0] A_STATE   = ADDR_BITS'(MM_STATE);
   localparam logic [ADDR_BITS-1:0] A_CTRL    = ADDR_BITS'(MM_CTRL);
   localparam logic [ADDR_BITS-1:0] A_STATUS  = ADDR_BITS'(MM_STATUS);
   localparam logic [ADDR_BITS-1:0] A_INSTCNT = ADDR_BITS'(MM_INSTCNT);
   localparam logic [ADDR_BITS-1:0] A_CYCCNT  = ADDR_BITS'(MM_CYCCNT);

   logic                 ctrl_wr;
   logic                 status_wr;
   logic                 ctrl_go;
   logic                 halted;
   logic [WORD_BITS-1:0] rd_mux;

   assign ctrl_wr   = write && (addr == A_CTRL);
   assign status_wr = write && (addr == A_STATUS);
   assign state_wr  = write && (addr == A_STATE);
   // go acts in the write cycle itself so HALT can dispatch without an extra cycle
   assign go_now    = ctrl_wr && writedata[CTRL_GO];
   assign halted    = (state == ST_HALT);

   // CTRL bits and sticky error flag; go only lives for one cycle after its write
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_boot <= 1'b0;
         ctrl_step <= 1'b0;
         ctrl_go   <= 1'b0;
         err       <= 1'b0;
      end else begin
         ctrl_go <= 1'b0;
         if (ctrl_wr) begin
            ctrl_boot <= writedata[CTRL_BOOT];
            ctrl_step <= writedata[CTRL_STEP];
            ctrl_go   <= writedata[CTRL_GO];
         end
         // a new timeout beats a simultaneous clear so an error is never lost
         if (err_set)
            err <= 1'b1;
         else if (status_wr && writedata[STAT_ERR])
            err <= 1'b0;
      end
   end

`ifdef CPU_CTRL_PERF_CNT_EN
   logic [WORD_BITS-1:0] instcnt;
   logic [WORD_BITS-1:0] cyccnt;

   // Free-running perf counters; any MM write to a counter clears it
   always_ff @(posedge clk) begin
      if (!rst) begin
         instcnt <= '0;
         cyccnt  <= '0;
      end else begin
         if (write && (addr == A_INSTCNT))
            instcnt <= '0;
         else if (inst_complete)
            instcnt <= instcnt + 1'b1;
         if (write && (addr == A_CYCCNT))
            cyccnt <= '0;
         else if (cyc_active)
            cyccnt <= cyccnt + 1'b1;
      end
   end
`else
   logic unused_perf;
   assign unused_perf = ^{inst_complete, cyc_active, writedata};
`endif

   // Read mux; unmapped addresses return zero
   always_comb begin
      rd_mux = '0;
      case (addr)
         A_STATE:   rd_mux = WORD_BITS'(state);
         A_CTRL:    rd_mux = WORD_BITS'({ctrl_go, ctrl_step, ctrl_boot});
         A_STATUS:  rd_mux = WORD_BITS'({halted, err});
`ifdef CPU_CTRL_PERF_CNT_EN
         A_INSTCNT: rd_mux = instcnt;
         A_CYCCNT:  rd_mux = cyccnt;
`endif
         default:   rd_mux = '0;
      endcase
   end

   // Registered read response
   always_ff @(posedge clk) begin
      if (!rst) begin
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= read;
         if (read)
            readdata <= rd_mux;
      end
   end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/calc/load-store sequencer with branch resolve, single-step and watchdog.
// Latency: permits are registered state decodes; unit completions act one cycle after arrival.
// Backpressure: waits indefinitely on unit completions, bounded by the watchdog (-> ERROR).
// Optional perf counters in cpu_ctrl_mmregs are enabled by CPU_CTRL_PERF_CNT_EN.
module cpu_ctrl_seq
   import cpu_ctrl_seq_pkg::*;
#(
   parameter int WORD_BITS      = 32,
   parameter int BURST_LENGTH   = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_BITS      = 3
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_BITS-1:0] i_inst,
   input  logic                 i_inst_valid,
   input  logic                 i_empty,
   input  logic                 i_fetch_complete,
   input  logic                 i_calc_complete,
   input  logic                 i_read_mem_complete,
   input  logic                 i_write_mem_complete,
   input  logic [WORD_BITS-1:0] i_src0,
   input  logic [WORD_BITS-1:0] i_src1,
   input  logic                 i_boot_sw,
   output logic                 o_permit_fetch,
   output logic                 o_calc_start,
   output logic                 o_lwst_start,
   output logic                 o_be_bne,
   output logic                 o_inst_complete,
   output logic                 o_halted,
   output logic                 o_error,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic                 i_read,
   input  logic                 i_write,
   input  logic [WORD_BITS-1:0] i_writedata,
   output logic [WORD_BITS-1:0] o_readdata,
   output logic                 o_readdatavalid
);

   localparam int              WD_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      BURST_LAST = 4'(BURST_LENGTH - 1);

   logic [3:0]      state;
   logic [3:0]      state_next;
   logic [3:0]      disp_next;
   logic [3:0]      burst_cnt;
   logic [WD_W-1:0] wd_cnt;
   logic            complete_next;
   logic            cmp_any;
   logic            in_wait;
   logic            timeout;
   logic            err_set;
   logic            wr_state_ok;
   dec_t            dec;

   logic ctrl_boot;
   logic ctrl_step;
   logic go_now;
   logic state_wr;
   logic cyc_active;

   logic unused_inst;
   assign unused_inst = ^i_inst;

   assign dec = decode(i_inst_valid,
                       i_inst[TYPE_LSB +: TYPE_W],
                       i_inst[OP_LSB +: OP_W],
                       (i_src0 == i_src1));

   assign cmp_any     = i_calc_complete || i_read_mem_complete || i_write_mem_complete;
   assign in_wait     = (state == ST_WAIT_FETCH) || (state == ST_WAIT_CALC) || (state == ST_WAIT_LWST);
   assign wr_state_ok = (i_writedata <= WORD_BITS'(ST_ERROR));
   assign cyc_active  = (state != ST_READY) && (state != ST_HALT) && (state != ST_ERROR);

   assign o_permit_fetch  = (state == ST_FETCH);
   assign o_calc_start    = (state == ST_CALC);
   assign o_lwst_start    = (state == ST_LWST);
   assign o_halted        = (state == ST_HALT);
   assign o_be_bne        = dec.be || dec.bne;
   assign o_inst_complete = cmp_any || dec.is_j;

   // Common dispatch choice after a retire or a go; an idle head keeps the current state
   always_comb begin
      disp_next = state;
      if (i_empty || dec.jump)
         disp_next = ST_FETCH;
      else if (dec.calc)
         disp_next = ST_CALC;
      else if (dec.lwst)
         disp_next = ST_LWST;
   end

   // Next-state logic; a host write to STATE overrides everything the FSM wanted
   always_comb begin
      state_next = state;
      timeout    = 1'b0;
      case (state)
         ST_READY:
            if (i_boot_sw || ctrl_boot)
               state_next = ST_FETCH;
         ST_FETCH:
            if (burst_cnt == BURST_LAST)
               state_next = ST_WAIT_FETCH;
         ST_WAIT_FETCH:
            if (i_fetch_complete) begin
               if (dec.jump)
                  state_next = ST_FETCH;
               else if (dec.calc)
                  state_next = ST_CALC;
               else if (dec.lwst)
                  state_next = ST_LWST;
               else
                  state_next = ST_FETCH;
            end else if (wd_cnt == WD_LAST) begin
               timeout = 1'b1;
            end
         ST_CALC:
            state_next = ST_WAIT_CALC;
         ST_LWST:
            state_next = ST_WAIT_LWST;
         ST_WAIT_CALC, ST_WAIT_LWST:
            if (complete_next)
               state_next = ctrl_step ? ST_HALT : disp_next;
            else if (wd_cnt == WD_LAST)
               timeout = 1'b1;
         ST_HALT:
            if (go_now)
               state_next = disp_next;
         ST_ERROR:
            state_next = ST_ERROR;
         default:
            state_next = ST_ERROR;
      endcase
      if (timeout)
         state_next = ST_ERROR;
      if (state_wr)
         state_next = wr_state_ok ? i_writedata[3:0] : ST_ERROR;
   end

   // A timeout only flags an error if the host did not redirect the FSM that cycle
   assign err_set = timeout && !state_wr;

   // State register, burst counter, watchdog and registered unit completion
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= ST_READY;
         burst_cnt     <= '0;
         wd_cnt        <= '0;
         complete_next <= 1'b0;
      end else begin
         state         <= state_next;
         complete_next <= cmp_any;
         if ((state == ST_FETCH) && (state_next == ST_FETCH))
            burst_cnt <= burst_cnt + 1'b1;
         else
            burst_cnt <= '0;
         if (in_wait && (state_next == state))
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
      end
   end

   cpu_ctrl_mmregs #(
      .WORD_BITS (WORD_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_mmregs (
      .clk           (clk),
      .rst           (rst),
      .addr          (i_addr),
      .read          (i_read),
      .write         (i_write),
      .writedata     (i_writedata),
      .state         (state),
      .err_set       (err_set),
      .inst_complete (o_inst_complete),
      .cyc_active    (cyc_active),
      .ctrl_boot     (ctrl_boot),
      .ctrl_step     (ctrl_step),
      .go_now        (go_now),
      .state_wr      (state_wr),
      .err           (o_error),
      .readdata      (o_readdata),
      .readdatavalid (o_readdatavalid)
   );

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Parametrised next-generation sequencer for the modakio CPU; replaces the fixed-burst fetch/calc/load-store control FSM.
- Issues fetch permits, dispatches decoded instructions to the calc or load/store units, and resolves BE/BNE branches.
- Adds single-step halt mode, a wait-state watchdog with sticky error, and a wider memory-mapped (MM) register file.
- Sits between the fetch buffer, the ALU/memory units and the MM host bus.

Parameters:
- WORD_BITS, 32, instruction/data/MM word width.
- BURST_LENGTH, 4, fetch-permit cycles per FETCH visit (1..16).
- TIMEOUT_CYCLES, 1024, wait-state cycles before watchdog error (>=2).
- ADDR_BITS, 3, MM register address width.

Ports:
- clk in 1: sole clock.
- rst in 1: synchronous reset, active-low (0 = reset, sampled on posedge clk).
- i_inst in WORD_BITS: head instruction from the fetch buffer.
- i_inst_valid in 1: i_inst is valid.
- i_empty in 1: fetch buffer is empty.
- i_fetch_complete in 1: burst fetch done (pulse).
- i_calc_complete in 1: ALU done (pulse).
- i_read_mem_complete in 1: load done (pulse).
- i_write_mem_complete in 1: store done (pulse).
- i_src0, i_src1 in WORD_BITS: branch compare operands.
- i_boot_sw in 1: board boot switch.
- o_permit_fetch out 1: high while in FETCH.
- o_calc_start out 1: high while in CALC.
- o_lwst_start out 1: high while in LWST.
- o_be_bne out 1: taken branch (combinational).
- o_inst_complete out 1: retire pulse (combinational).
- o_halted out 1: high in HALT.
- o_error out 1: sticky watchdog flag.
- i_addr in ADDR_BITS: MM word address.
- i_read in 1: MM read strobe.
- i_write in 1: MM write strobe.
- i_writedata in WORD_BITS: MM write data.
- o_readdata out WORD_BITS: MM read data.
- o_readdatavalid out 1: MM read data valid.

Behaviour:
- Reset: state=READY. All registers and outputs 0, except o_readdata=0 and o_readdatavalid=0.
- Decode: type/op fields are taken from package offsets.
  - lwst = valid & TYPE_I & (OP_LW|OP_ST).
  - be = valid & TYPE_I & OP_BE & (src0==src1).
  - bne = valid & TYPE_I & OP_BNE & (src0!=src1).
  - jump = valid & (TYPE_LR&OP_JR | TYPE_J&(OP_J|OP_JAL)) | be | bne.
  - calc = valid & !lwst & !jump.
- "dispatch": empty or jump -> FETCH; calc -> CALC; lwst -> LWST; otherwise stay.
- READY -> FETCH when i_boot_sw or CTRL.boot.
- FETCH: 4-bit counter increments each cycle in FETCH and clears elsewhere. At count BURST_LENGTH-1 -> WAIT_FETCH, so o_permit_fetch is high exactly BURST_LENGTH cycles.
- WAIT_FETCH: on i_fetch_complete, jump -> FETCH, calc -> CALC, lwst -> LWST.
- CALC (1 cycle) -> WAIT_CALC. LWST (1 cycle) -> WAIT_LWST.
- WAIT_CALC / WAIT_LWST:
  - Completion inputs are registered one cycle (complete_next).
  - On complete_next: if CTRL.step, go to HALT; else dispatch.
- HALT: holds until CTRL.go is written to 1, then dispatches in that same cycle. CTRL.go self-clears next cycle.
- Watchdog:
  - Counter runs in WAIT_FETCH/WAIT_CALC/WAIT_LWST and clears on any state change.
  - If it reaches TIMEOUT_CYCLES-1 with no completion -> ERROR and sets STATUS.err.
  - Completion arriving on the terminal cycle wins over the timeout.
- ERROR exits only by an MM write to STATE or by reset.
- MM write to STATE has priority over every FSM transition. Writing an undefined encoding forces ERROR.
- Simultaneous completion pulses: any one counts as completion.
- o_inst_complete = any completion pulse | (TYPE_J & valid).
- Reset mid-burst or mid-wait returns to READY; in-flight completions are ignored.
- MM read: o_readdata registered; o_readdatavalid = i_read delayed 1 cycle. Unmapped addresses read 0.
- MM map:
  - 0 STATE (rw).
  - 1 CTRL: bit0 boot, bit1 step, bit2 go (self-clearing).
  - 2 STATUS: bit0 err (write 1 to clear); bit1 halted (ro).
  - 3 INSTCNT, 4 CYCCNT (feature only).

Optional Feature:
- Macro: CPU_CTRL_PERF_CNT_EN.
- Defined:
  - INSTCNT (WORD_BITS) increments per o_inst_complete.
  - CYCCNT increments every cycle outside READY/HALT/ERROR.
  - Both wrap at 2^WORD_BITS and clear on an MM write of any value.
- Undefined: addresses 3/4 read 0, writes are ignored, no counter flops.

Decomposition:
- Shared package/define file holds:
  - state encodings (READY=0, FETCH=1, WAIT_FETCH=2, CALC=3, WAIT_CALC=4, LWST=5, WAIT_LWST=6, HALT=7, ERROR=8);
  - TYPE_*/OP_* codes and field offsets;
  - MM address constants.
- One sub-module, cpu_ctrl_mmregs: CTRL/STATUS/perf registers and the read mux. The FSM stays in the top module.

Test Plan:
- Boot with BURST_LENGTH=4: i_boot_sw=1 -> o_permit_fetch high exactly 4 cycles, then state reads 2.
- ADD after fetch complete: i_calc_complete 3 cycles later -> CALC 1 cycle; returns to FETCH with i_empty=1, o_inst_complete pulses once.
- BE with src0=src1=5 -> o_be_bne=1, direct WAIT_FETCH->FETCH. With src1=6 -> o_be_bne=0, dispatched to CALC.
- Single-step: CTRL=0x2 with an LW queued -> HALT after the LW, o_halted=1. Writing CTRL=0x6 -> LWST next cycle.
- Watchdog TIMEOUT_CYCLES=16, no completion -> ERROR after 16 wait cycles, o_error=1. STATUS write 1 clears err; STATE write 0 -> READY.
- With CPU_CTRL_PERF_CNT_EN, 3 retired instructions -> INSTCNT reads 3 with o_readdatavalid one cycle after i_read. Without the macro -> reads 0.
